// File: rtl/wb_obi_bridge.sv
// Wishbone-classic slave to OBI master bridge. One transfer in flight, registered outputs.
// FSM encoding on dbg_state: 0=IDLE, 1=REQ, 2=RESP, 3=DONE.
module wb_obi_bridge #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [DATA_WIDTH/8-1:0]   wbs_sel_i,
    input  logic [ADDR_WIDTH-1:0]     wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]     wbs_dat_i,
    output logic [DATA_WIDTH-1:0]     wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic                      wbs_err_o,
    output logic                      obi_req_o,
    input  logic                      obi_gnt_i,
    output logic [31:0]               obi_addr_o,
    output logic                      obi_we_o,
    output logic [DATA_WIDTH/8-1:0]   obi_be_o,
    output logic [DATA_WIDTH-1:0]     obi_wdata_o,
    input  logic                      obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     obi_rdata_i,
    input  logic                      obi_err_i,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    logic   live;

    assign dbg_state = state;

    // Handshakes: a WB strobe is taken only in IDLE and answered by one ack/err
    // pulse; the OBI request holds every field stable until the cycle gnt is seen,
    // and rvalid (which qualifies err/rdata) is only looked at after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            live        <= 1'b0;
            wbs_dat_o   <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            obi_req_o   <= 1'b0;
            obi_addr_o  <= '0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_wdata_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        obi_addr_o  <= (BASE_ADDR + 32'(wbs_adr_i)) & 32'hFFFF_FFFC;
                        obi_we_o    <= wbs_we_i;
                        obi_be_o    <= wbs_sel_i;
                        obi_wdata_o <= wbs_dat_i;
                        obi_req_o   <= 1'b1;
                        live        <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    // The request stays up until granted even if the WB side gives up.
                    if (!wbs_cyc_i) live <= 1'b0;
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (obi_rvalid_i) begin
                        if (!live || !wbs_cyc_i) begin
                            live  <= 1'b0;
                            state <= IDLE;
                        end else if (obi_err_i) begin
                            wbs_err_o <= 1'b1;
                            state     <= DONE;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            if (!obi_we_o) wbs_dat_o <= obi_rdata_i;
                            state <= DONE;
                        end
                    end else if (!wbs_cyc_i) begin
                        live <= 1'b0;
                    end
                end
                DONE: begin
                    live  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_obi_bridge.md
# wb_obi_bridge

Wishbone-classic slave to OBI master bridge: lets an external Wishbone initiator (host/debug path behind the `wb_arbiter_2` fabric) reach the core-side OBI memory port, e.g. the SoC RAM behind `wb_*_i` inputs. It is the reverse of the OBI-to-WB bridge: one outstanding transfer at a time, registered outputs, strict OBI request stability. It converts a Wishbone strobe into an OBI address phase and response phase, then returns a single-cycle Wishbone ack or err.

## Interface
- `ADDR_WIDTH`, 20: Wishbone byte-address width, 2..32.
- `DATA_WIDTH`, 32: data width; only 32 supported.
- `BASE_ADDR`, 32'h0000_0000: added to the WB address to form the OBI address.
- `clk`  in  1  bridge clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wbs_cyc_i`  in  1  WB cycle.
- `wbs_stb_i`  in  1  WB strobe.
- `wbs_we_i`  in  1  WB write enable.
- `wbs_sel_i`  in  4  WB byte select.
- `wbs_adr_i`  in  ADDR_WIDTH  WB byte address.
- `wbs_dat_i`  in  32  WB write data.
- `wbs_dat_o`  out  32  WB read data.
- `wbs_ack_o`  out  1  WB ack, one-cycle pulse.
- `wbs_err_o`  out  1  WB error, one-cycle pulse.
- `obi_req_o`  out  1  OBI request.
- `obi_gnt_i`  in  1  OBI grant.
- `obi_addr_o`  out  32  OBI address, word aligned.
- `obi_we_o`  out  1  OBI write enable.
- `obi_be_o`  out  4  OBI byte enables.
- `obi_wdata_o`  out  32  OBI write data.
- `obi_rvalid_i`  in  1  OBI response valid.
- `obi_rdata_i`  in  32  OBI read data.
- `obi_err_i`  in  1  OBI response error, qualified by `obi_rvalid_i`.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - On `wbs_cyc_i & wbs_stb_i`, latch `we`, `sel`, `dat_i` and address.
  - Latched address is `(BASE_ADDR + zero-extended wbs_adr_i) mod 2^32`, with bits [1:0] forced to 0.
  - Latch a `live` flag = 1, then go to REQ.
- REQ:
  - Drive `obi_req_o`=1 with the latched addr/we/be/wdata, all stable.
  - On `obi_gnt_i`, go to RESP.
  - Request is never withdrawn before grant, even if `wbs_cyc_i` drops.
- RESP:
  - `obi_req_o`=0. Wait for `obi_rvalid_i`.
  - If rvalid, `live`, and no error: go to DONE with ack. On a read, also load `wbs_dat_o` ← `obi_rdata_i`.
  - If rvalid with `obi_err_i`: go to DONE with err; `wbs_dat_o` is unchanged.
  - If rvalid and not `live`: go to IDLE with no ack/err and discard the data.
- DONE: exactly one of `wbs_ack_o`/`wbs_err_o` is high for one cycle, then go to IDLE.
- Abort: `wbs_cyc_i` low in any cycle of REQ or RESP clears `live`. The OBI transfer still completes and the response is dropped.
- Writes leave `wbs_dat_o` unchanged. `wbs_dat_o` holds the last read value indefinitely.
- A new WB strobe is accepted only in IDLE. While busy, further strobes are ignored because the slave stalls by not acking.
- Reset:
  - All outputs 0: `wbs_dat_o`=0, ack/err=0, `obi_req_o`=0, addr/be/wdata/we=0.
  - FSM goes to IDLE, `live`=0.
  - Reset mid-transfer aborts immediately; the outstanding OBI transfer is abandoned. This is allowed only under global reset.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Cycle 0: strobe sampled in IDLE.
- Cycle 1: `obi_req_o` high.
- With gnt in cycle 1 and rvalid in cycle 2, ack/err is high in cycle 3. The minimum latency is 3 cycles from strobe to ack.
- Each gnt stall cycle adds one cycle. Each cycle of rvalid delay after grant adds one cycle.
- `obi_rvalid_i` is never expected in the same cycle as grant; the OBI slave guarantees at least one cycle.
- The WB master drops `stb` the cycle after it sees ack. The bridge is back in IDLE in that cycle, so it accepts back-to-back strobes. Throughput is one transfer per 4 cycles minimum.
- `obi_be_o` equals the latched `wbs_sel_i` verbatim for both reads and writes. `obi_we_o` equals the latched `wbs_we_i`.

## Test plan
- Read, zero wait:
  - Setup: BASE_ADDR=0x0008_0000, adr=0x00124, OBI returns 0xDEADBEEF with gnt in cycle 1 and rvalid in cycle 2.
  - Required: `obi_addr_o`=0x0008_0124, `obi_be_o`=0xF, `wbs_dat_o`=0xDEADBEEF, ack in cycle 3 only.
- Byte write with 3 grant stalls:
  - Setup: we=1, sel=0x2, dat=0x0000_AB00.
  - Required: req, addr and wdata stay stable for 4 cycles, ack in cycle 6, `wbs_dat_o` unchanged from the prior value.
- OBI error response:
  - Setup: read with `obi_err_i`=1 on rvalid.
  - Required: `wbs_err_o` pulses for 1 cycle, no ack, `wbs_dat_o` keeps the previous value.
- Abort:
  - Setup: cyc drops during a grant stall.
  - Required: req held until gnt, rvalid consumed, no ack/err, FSM back in IDLE. A following read to 0x00000 completes normally.
- Address wrap and alignment:
  - Setup: BASE_ADDR=0xFFFF_FFF0, adr=0x00023.
  - Required: `obi_addr_o`=0x0000_0010.
- Reset mid-transfer:
  - Setup: assert `rst_n` low in RESP.
  - Required: all outputs 0 asynchronously. After release, a new read succeeds with `wbs_dat_o` updated.
